// File: rtl/sha1_engine.sv
// rtl/sha1_engine.sv - SHA-1 block engine with a register-mapped 512-bit message buffer
// Optional macro SHA1_BUSY_STALL_EN: writes while busy are stalled via reqready instead of errored.
module sha1_engine #(
    parameter int DataWidth = 64,
    parameter int AddrWidth = 32,
    parameter int ByteAlign = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [DataWidth-1:0]   sha_s_reqdata_i,
    input  logic [AddrWidth-1:0]   sha_s_reqaddr_i,
    input  logic                   sha_s_reqvalid_i,
    input  logic                   sha_s_reqwrite_i,
    input  logic [DataWidth/8-1:0] sha_s_reqstrobe_i,
    output logic                   sha_s_reqready_o,
    input  logic                   sha_s_rspready_i,
    output logic                   sha_s_rspvalid_o,
    output logic [DataWidth-1:0]   sha_s_rspdata_o,
    output logic                   sha_s_rsperror_o,
    input  logic                   sha_init_i,
    input  logic                   sha_next_i,
    output logic                   sha_busy_o,
    output logic [159:0]           sha_digest_o,
    output logic                   sha_digestvalid_o,
    input  logic                   sha_digestack_i
);
    localparam int NumRegs   = 512 / DataWidth;
    localparam int AddrStep  = (ByteAlign != 0) ? DataWidth / 8 : DataWidth / 32;
    localparam int StrbWidth = DataWidth / 8;
    localparam int SelWidth  = $clog2(NumRegs);
    localparam logic [159:0] Iv = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

    typedef enum logic [1:0] {IDLE, ROUND, UPDATE, DONE} state_e;

    state_e                 state_q, state_d;
    logic [DataWidth-1:0]   regs_q [NumRegs];
    logic [511:0]           block;
    logic [SelWidth-1:0]    sel;
    logic                   hit, start, wr_blocked, stall, wr_en, rsp_fire;
    logic [6:0]             t_q;
    logic [31:0]            a_q, b_q, c_q, d_q, e_q, f, k, temp, w_new;
    logic [31:0]            w_q [16];
    logic [159:0]           h_q, h_base;
    logic                   use_iv_q, digest_valid_q, rsp_valid_q;
    logic [DataWidth-1:0]   rsp_data_q;

    always_comb begin
        hit   = 1'b0;
        sel   = '0;
        block = '0;
        for (int r = 0; r < NumRegs; r++) begin
            if (sha_s_reqaddr_i == AddrWidth'(r * AddrStep)) begin
                hit = 1'b1;
                sel = SelWidth'(r);
            end
            block[r*DataWidth +: DataWidth] = regs_q[r];
        end
    end

`ifdef SHA1_BUSY_STALL_EN
    assign wr_blocked = 1'b0;
    assign stall      = sha_s_reqvalid_i & sha_s_reqwrite_i & sha_busy_o;
`else
    assign wr_blocked = sha_busy_o;
    assign stall      = 1'b0;
`endif

    // Gated by rst_ni so the error flag reads 0 (and reqready 1) throughout reset.
    assign sha_s_rsperror_o  = rst_ni & sha_s_reqvalid_i & sha_s_reqwrite_i & (~hit | wr_blocked);
    assign sha_s_reqready_o  = ~sha_s_rsperror_o & ~stall;
    assign wr_en             = sha_s_reqvalid_i & sha_s_reqwrite_i & hit & sha_s_reqready_o;
    assign rsp_fire          = sha_s_reqvalid_i & sha_s_rspready_i & hit & ~stall;
    assign start             = ((state_q == IDLE) || (state_q == DONE)) & (sha_init_i | sha_next_i);
    assign sha_s_rspvalid_o  = rsp_valid_q;
    assign sha_s_rspdata_o   = rsp_data_q;
    assign sha_digest_o      = h_q;
    assign sha_digestvalid_o = digest_valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ROUND;
            ROUND:   if (t_q == 7'd79) state_d = UPDATE;
            UPDATE:  state_d = DONE;
            DONE: begin
                if (start)                state_d = ROUND;
                else if (sha_digestack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sha_busy_o = (state_q == ROUND) || (state_q == UPDATE);
    end

    always_comb begin
        if (t_q < 7'd20) begin
            f = (b_q & c_q) | (~b_q & d_q);
            k = 32'h5A827999;
        end else if (t_q < 7'd40) begin
            f = b_q ^ c_q ^ d_q;
            k = 32'h6ED9EBA1;
        end else if (t_q < 7'd60) begin
            f = (b_q & c_q) | (b_q & d_q) | (c_q & d_q);
            k = 32'h8F1BBCDC;
        end else begin
            f = b_q ^ c_q ^ d_q;
            k = 32'hCA62C1D6;
        end
        temp   = {a_q[26:0], a_q[31:27]} + f + e_q + k + w_q[0];
        w_new  = w_q[13] ^ w_q[8] ^ w_q[2] ^ w_q[0];
        w_new  = {w_new[30:0], w_new[31]};
        h_base = use_iv_q ? Iv : h_q;
    end

    // H is only rewritten in UPDATE; an init pulse remembers to add onto the IV instead.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            t_q      <= '0;
            {a_q, b_q, c_q, d_q, e_q} <= '0;
            h_q      <= Iv;
            use_iv_q <= 1'b0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else begin
            case (state_q)
                ROUND: begin
                    a_q <= temp;
                    b_q <= a_q;
                    c_q <= {b_q[1:0], b_q[31:2]};
                    d_q <= c_q;
                    e_q <= d_q;
                    t_q <= t_q + 7'd1;
                    for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
                    w_q[15] <= w_new;
                end
                UPDATE: begin
                    h_q <= {h_base[159:128] + a_q, h_base[127:96] + b_q, h_base[95:64] + c_q,
                            h_base[63:32] + d_q, h_base[31:0] + e_q};
                end
                default: begin
                    if (start) begin
                        {a_q, b_q, c_q, d_q, e_q} <= sha_init_i ? Iv : h_q;
                        use_iv_q <= sha_init_i;
                        t_q      <= '0;
                        for (int i = 0; i < 16; i++) w_q[i] <= block[511-32*i -: 32];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NumRegs; r++) regs_q[r] <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            digest_valid_q <= 1'b0;
        end else begin
            if (wr_en) begin
                for (int b = 0; b < StrbWidth; b++)
                    if (sha_s_reqstrobe_i[b]) regs_q[sel][8*b +: 8] <= sha_s_reqdata_i[8*b +: 8];
            end
            rsp_valid_q <= rsp_fire;
            if (rsp_fire) rsp_data_q <= regs_q[sel];
            digest_valid_q <= (state_q == DONE) & ~start & ~sha_digestack_i;
        end
    end
endmodule

// File: tb/tb_sha1_engine.sv
// tb/tb_sha1_engine.sv - randomized self-checking bench for sha1_engine against a behavioural SHA-1 model
module tb_sha1_engine;
    localparam int DW = 64;
    localparam int NR = 8;
    localparam int STEP = 8;
    localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_ni = 1'b0;
    logic [DW-1:0] reqdata = '0;
    logic [31:0] reqaddr = '0;
    logic reqvalid = 1'b0, reqwrite = 1'b0, rspready = 1'b1;
    logic [7:0] reqstrobe = '0;
    logic init_p = 1'b0, next_p = 1'b0, ack = 1'b0;
    logic reqready, rspvalid, rsperror, busy, dvalid;
    logic [DW-1:0] rspdata;
    logic [159:0] digest;

    sha1_engine dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .sha_s_reqdata_i(reqdata), .sha_s_reqaddr_i(reqaddr), .sha_s_reqvalid_i(reqvalid),
        .sha_s_reqwrite_i(reqwrite), .sha_s_reqstrobe_i(reqstrobe),
        .sha_s_reqready_o(reqready), .sha_s_rspready_i(rspready), .sha_s_rspvalid_o(rspvalid),
        .sha_s_rspdata_o(rspdata), .sha_s_rsperror_o(rsperror),
        .sha_init_i(init_p), .sha_next_i(next_p), .sha_busy_o(busy),
        .sha_digest_o(digest), .sha_digestvalid_o(dvalid), .sha_digestack_i(ack)
    );

    int total = 0, bad = 0;
    bit chk_en = 1'b0;
    logic [DW-1:0] m_regs [NR];
    logic [159:0] m_h, m_pend;
    int phase = -1;
    logic exp_dv = 1'b0;

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [159:0] sha1_blk(input logic [159:0] hin, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, tmp;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 80; t++) w[t] = rotl(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
        {a, b, c, d, e} = hin;
        for (int t = 0; t < 80; t++) begin
            case (t / 20)
                0:       begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
                1:       begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
                2:       begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
                default: begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            endcase
            tmp = rotl(a, 5) + f + e + k + w[t];
            e = d; d = c; c = rotl(b, 30); b = a; a = tmp;
        end
        return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
    endfunction

    function automatic logic [511:0] m_block();
        logic [511:0] blk;
        for (int r = 0; r < NR; r++) blk[r*DW +: DW] = m_regs[r];
        return blk;
    endfunction

    function automatic bit m_hit(input logic [31:0] addr);
        return (addr < NR * STEP) && (addr % STEP == 0);
    endfunction

    task automatic model_reset();
        phase = -1; exp_dv = 1'b0; m_h = IV;
        for (int r = 0; r < NR; r++) m_regs[r] = '0;
    endtask

    // One clock: capture what is driven, let the edge pass, then advance the model.
    task automatic tick();
        logic c_init = init_p, c_next = next_p, c_ack = ack, c_v = reqvalid, c_w = reqwrite;
        logic [31:0] c_addr = reqaddr;
        logic [DW-1:0] c_data = reqdata;
        logic [7:0] c_strb = reqstrobe;
        int p;
        @(posedge clk); #1;
        if (!rst_ni) begin model_reset(); return; end
        p = phase;
        if (p >= 0 && p <= 80) begin
            phase = p + 1;
            if (phase == 81) m_h = m_pend;
        end else begin
            if (c_init || c_next) begin
                m_pend = sha1_blk(c_init ? IV : m_h, m_block());
                phase = 0; exp_dv = 1'b0;
            end else if (c_ack && p >= 81) begin
                phase = -1; exp_dv = 1'b0;
            end else if (p == 81) begin
                phase = 82; exp_dv = 1'b1;
            end
            if (c_v && c_w && m_hit(c_addr))
                for (int b = 0; b < 8; b++)
                    if (c_strb[b]) m_regs[c_addr/STEP][8*b +: 8] = c_data[8*b +: 8];
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, (phase >= 0 && phase <= 80));
            check("digestvalid", dvalid, exp_dv);
            check("digest", digest, m_h);
            if (!rst_ni) check("reqready_in_reset", reqready, 1'b1);
        end
    end

    task automatic wr(input logic [31:0] addr, input logic [DW-1:0] data, input logic [7:0] strb,
                      input bit exp_err);
        logic [DW-1:0] pre;
        bit h = m_hit(addr);
        pre = h ? m_regs[addr/STEP] : '0;
        reqvalid = 1; reqwrite = 1; reqaddr = addr; reqdata = data; reqstrobe = strb;
        #1;
        check("wr_error", rsperror, exp_err);
        check("wr_ready", reqready, !exp_err);
        tick();
        reqvalid = 0; reqwrite = 0;
        if (!exp_err || !h) check("wr_rspvalid", rspvalid, h);
        if (!exp_err) check("wr_rspdata", rspdata, pre);
    endtask

    task automatic rd(input int r);
        logic [DW-1:0] exp = m_regs[r];
        reqvalid = 1; reqwrite = 0; reqaddr = r * STEP;
        tick();
        reqvalid = 0;
        check("rd_rspvalid", rspvalid, 1'b1);
        check("rd_rspdata", rspdata, exp);
    endtask

    task automatic load(input logic [511:0] blk);
        for (int r = 0; r < NR; r++) wr(r * STEP, blk[r*DW +: DW], 8'hFF, 1'b0);
    endtask

    task automatic start(input bit use_init);
        init_p = use_init; next_p = !use_init;
        tick();
        init_p = 0; next_p = 0;
    endtask

    task automatic wait_dv(output int k);
        for (k = 0; k < 120 && !dvalid; k++) tick();
        check("dv_timeout", dvalid, 1'b1);
    endtask

    task automatic do_ack();
        ack = 1; tick(); ack = 0;
    endtask

    logic [511:0] abc_blk, empty_blk, long1_blk, long2_blk;
    int k;

    initial begin
        abc_blk   = {32'h61626380, 448'h0, 32'h00000018};
        empty_blk = {32'h80000000, 480'h0};
        long1_blk = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
                     32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
                     32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h0};
        long2_blk = {480'h0, 32'h000001c0};
        model_reset();
        check("pin_model_abc", sha1_blk(IV, abc_blk), 160'ha9993e364706816aba3e25717850c26c9cd0d89d);
        check("pin_model_empty", sha1_blk(IV, empty_blk), 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709);
        check("pin_model_long", sha1_blk(sha1_blk(IV, long1_blk), long2_blk),
              160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1);

        repeat (2) tick();
        rst_ni = 1; chk_en = 1;
        check("rst_busy", busy, 1'b0);
        check("rst_dv", dvalid, 1'b0);
        check("rst_digest", digest, IV);
        check("rst_rspvalid", rspvalid, 1'b0);
        check("rst_reqready", reqready, 1'b1);
        rd(0); rd(7);

        load(abc_blk);
        start(1'b1);
        wait_dv(k);
        check("abc_latency", k, 82);
        check("abc_digest", digest, 160'ha9993e364706816aba3e25717850c26c9cd0d89d);
        repeat (3) tick();
        do_ack();

        load(empty_blk);
        start(1'b1);
        wait_dv(k);
        check("empty_digest", digest, 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709);
        do_ack();

        load(long1_blk);
        start(1'b1);
        wait_dv(k);
        do_ack();
        load(long2_blk);
        start(1'b0);
        wait_dv(k);
        check("long_digest", digest, 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1);
        do_ack();

        wr(NR * STEP, 64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b1);
        for (int r = 0; r < NR; r++) rd(r);
        reqvalid = 1; reqwrite = 0; reqaddr = 0; rspready = 0;
        tick();
        reqvalid = 0; rspready = 1;
        check("rd_no_rspready", rspvalid, 1'b0);

        load(abc_blk);
        start(1'b1);
        repeat (40) tick();
`ifdef SHA1_BUSY_STALL_EN
        reqvalid = 1; reqwrite = 1; reqaddr = 0; reqdata = 64'h1122_3344_5566_7788; reqstrobe = 8'hFF;
        #1;
        check("stall_ready_low", reqready, 1'b0);
        check("stall_no_error", rsperror, 1'b0);
        for (int i = 0; i < 100 && !reqready; i++) tick();
        check("stall_release", reqready, 1'b1);
        tick();
        reqvalid = 0; reqwrite = 0;
        rd(0);
`else
        wr(0, 64'h1122_3344_5566_7788, 8'hFF, 1'b1);
`endif
        wait_dv(k);
        check("busy_wr_digest", digest, 160'ha9993e364706816aba3e25717850c26c9cd0d89d);
        do_ack();

        load(abc_blk);
        start(1'b1);
        repeat (50) tick();
        rst_ni = 0;
        model_reset();
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_dv", dvalid, 1'b0);
        check("midrst_digest", digest, IV);
        repeat (2) tick();
        rst_ni = 1;
        load(abc_blk);
        start(1'b1);
        wait_dv(k);
        check("post_rst_abc", digest, 160'ha9993e364706816aba3e25717850c26c9cd0d89d);
        do_ack();

        for (int it = 0; it < 6; it++) begin
            for (int j = 0; j < 12; j++) begin
                logic [31:0] a;
                a = ($urandom_range(0, 9) == 0) ? NR * STEP + 8 * $urandom_range(0, 3)
                                                : STEP * $urandom_range(0, NR - 1);
                if ($urandom_range(0, 3) == 0 && m_hit(a)) rd(a / STEP);
                else wr(a, {$urandom, $urandom}, 8'($urandom), !m_hit(a));
            end
            start(it == 0 || $urandom_range(0, 1) == 1);
            repeat ($urandom_range(1, 20)) tick();
            rd($urandom_range(0, NR - 1));
            wait_dv(k);
            if ($urandom_range(0, 1) == 1) do_ack();
            else repeat ($urandom_range(0, 3)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sha1_engine.md
SHA1_ENGINE -- requirements
Module: sha1_engine

Interface
REQ-001 SHALL have parameter DataWidth, default 64, meaning register bus data width; legal values are 32 and 64.
REQ-002 SHALL have parameter AddrWidth, default 32, meaning register bus address width.
REQ-003 SHALL have parameter ByteAlign, default 1, meaning 1 for byte addressing and 0 for 32-bit-word addressing; AddrStep = (DataWidth/8) or (DataWidth/32) respectively.
REQ-004 SHALL have port clk_i, input, 1, clock; all logic rises on the posedge.
REQ-005 SHALL have port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have ports sha_s_reqdata_i (input, DataWidth), sha_s_reqaddr_i (input, AddrWidth), sha_s_reqvalid_i (input, 1), sha_s_reqwrite_i (input, 1) and sha_s_reqstrobe_i (input, DataWidth/8); these form the register request.
REQ-007 SHALL have ports sha_s_reqready_o (output, 1), sha_s_rspready_i (input, 1), sha_s_rspvalid_o (output, 1), sha_s_rspdata_o (output, DataWidth) and sha_s_rsperror_o (output, 1); these form the handshake and response.
REQ-008 SHALL have port sha_init_i, input, 1, meaning a pulse that hashes the buffered block starting from the IV.
REQ-009 SHALL have port sha_next_i, input, 1, meaning a pulse that hashes the buffered block chained on the current H.
REQ-010 SHALL have port sha_busy_o, input/output direction output, 1, meaning high while rounds are in progress.
REQ-011 SHALL have ports sha_digest_o (output, 160), sha_digestvalid_o (output, 1) and sha_digestack_i (input, 1).

Function
REQ-012 SHALL hold a 512-bit block as NumRegs = 512/DataWidth registers, each with a byte strobe.
- Register r is selected when reqaddr[AddrBits-1:0] == r*AddrStep.
- Register r maps to block[r*DataWidth +: DataWidth].
- Message word W[t] = block[511-32t -: 32] for t = 0..15.
REQ-013 SHALL return the selected register's pre-write value on sha_s_rspdata_o, registered on the cycle after the request.
- rspvalid = reqvalid & rspready & (register hit).
REQ-014 SHALL raise sha_s_rsperror_o combinationally, with no register change, in two cases:
- a write to an unmapped address;
- a write while the FSM is not IDLE or DONE.
REQ-015 SHALL drive sha_s_reqready_o = ~sha_s_rsperror_o.
REQ-016 SHALL implement the FSM states IDLE, ROUND, UPDATE and DONE, with reset state IDLE.
REQ-017 SHALL, on sha_init_i or sha_next_i sampled high in IDLE or DONE:
- load A..E from IV (init) or from H (next);
- load the 16-word schedule from the block;
- clear the round counter t;
- clear sha_digestvalid_o;
- go to ROUND.
REQ-018 SHALL give sha_init_i priority when sha_init_i and sha_next_i are high in the same cycle.
REQ-019 SHALL ignore sha_init_i, sha_next_i and sha_digestack_i while in ROUND or UPDATE.
REQ-020 SHALL, in ROUND, perform exactly one SHA-1 round per cycle.
- f and K are selected by t ranges 0-19, 20-39, 40-59 and 60-79.
- W[t] for t>=16 = rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]), computed in a 16-entry shifting window.
- All additions are modulo 2^32.
REQ-021 SHALL leave ROUND for UPDATE after t = 79.
- UPDATE adds A..E into H0..H4 modulo 2^32 in one cycle, then goes to DONE.
REQ-022 SHALL assert sha_digestvalid_o exactly 82 cycles after the start pulse was sampled, and hold it in DONE until sha_digestack_i is sampled high (then IDLE) or a new start is accepted.
REQ-023 SHALL drive sha_digest_o = {H0,H1,H2,H3,H4} at all times, and hold it stable outside UPDATE.
REQ-024 SHALL drive sha_busy_o high exactly in ROUND and UPDATE.
REQ-025 SHALL accept reads in every state.
REQ-026 SHALL treat sha_next_i after reset with no prior init as chaining on the IV.

Reset
REQ-027 SHALL, on rst_ni low at any time including mid-round, set the following immediately:
- the FSM to IDLE;
- t, A..E, the block registers and rspdata to 0;
- H0..H4 to the IV 67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0;
- sha_busy_o, sha_digestvalid_o, sha_s_rspvalid_o and sha_s_rsperror_o to 0.
REQ-028 SHALL leave sha_s_reqready_o at 1 and sha_digest_o at the IV while in reset.

Configuration
REQ-029 SHALL support macro SHA1_BUSY_STALL_EN.
- When defined, a write while busy is not errored: sha_s_reqready_o is held low until the FSM reaches DONE or IDLE.
- When undefined, such a write gets the error of REQ-014.

Verification
REQ-030 SHALL cover the "abc" padded block with init: digest a9993e364706816aba3e25717850c26c9cd0d89d, with digestvalid high exactly 82 cycles after the pulse.
REQ-031 SHALL cover the empty-message padded block with init: digest da39a3ee5e6b4b0d3255bfef95601890afd80709.
REQ-032 SHALL cover the 56-byte "abcdbcdecdefdefg...nopq" message: block 1 with init, ack, block 2 with next gives 84983e441c3bd26ebaae4aa1f95129e5e54670f1.
REQ-033 SHALL cover a write to address NumRegs*AddrStep: rsperror=1 and reqready=0 in that cycle, no register changes, and rspvalid=0.
REQ-034 SHALL cover a write at round 40, with and without SHA1_BUSY_STALL_EN:
- without the macro: rsperror=1 and the digest is unaffected;
- with the macro: reqready=0 until DONE, then the write lands.
REQ-035 SHALL cover rst_ni low at round 50: busy=0, digestvalid=0 and digest=IV; a following "abc" init gives the correct digest.
